// File: rtl/serv_rf_arb_pkg.sv
// rtl/serv_rf_arb_pkg.sv - shared types and constants for the serv RF RAM arbiter
//
// Purpose: FSM state encoding, default burst length and burst counter width
//          used by serv_rf_ram_arb and its round-robin picker.
// Ports:   none (package).
package serv_rf_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_t;

    // Cycles one transaction owns the SRAM, counted from the forwarded pulse.
    localparam int BURST_DEFAULT = 36;

    // Counter wide enough for the largest legal burst (255).
    localparam int CNT_W = $clog2(256);

endpackage

// File: rtl/serv_rf_arb_rr.sv
// rtl/serv_rf_arb_rr.sv - 2-way round-robin picker for the RF RAM arbiter
//
// Purpose: picks one of two pending harts. A lone requester always wins; on a
//          tie the hart that was not granted last wins. The last-granted hart
//          resets to 1 so hart 0 wins the first tie.
// Ports:
//   i_clk, i_rst : clock, asynchronous active-high reset
//   i_pend[1:0]  : per-hart "has pending work" flags
//   i_en         : grant enable (arbiter free this cycle)
//   o_gnt[1:0]   : one-hot grant, zero when disabled or nothing pending
module serv_rf_arb_rr
    import serv_rf_arb_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [1:0] i_pend,
    input  logic       i_en,
    output logic [1:0] o_gnt
);

    logic last_q;
    logic last_d;

    always_comb begin
        o_gnt  = 2'b00;
        last_d = last_q;
        if (i_en) begin
            case (i_pend)
                2'b01:   o_gnt = 2'b01;
                2'b10:   o_gnt = 2'b10;
                2'b11:   o_gnt = last_q ? 2'b01 : 2'b10;
                default: o_gnt = 2'b00;
            endcase
        end
        if (o_gnt[0]) begin
            last_d = 1'b0;
        end else if (o_gnt[1]) begin
            last_d = 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/serv_rf_ram_arb.sv
// rtl/serv_rf_ram_arb.sv - shares one RF SRAM between two serv_rf_ram_if harts
//
// Purpose: serializes the two harts' register-file transactions onto a single
//          SRAM as fixed-length bursts, alternating round-robin on ties, and
//          prefixes the owning hart index onto the SRAM addresses.
// Optional feature: define SERV_RF_ARB_ERR_EN to make o_err a sticky flag for
//          SRAM strobes from the non-owner or while idle; otherwise o_err = 0.
//          Stray strobes are blocked from the SRAM either way.
// Ports:
//   i_clk, i_rst                     : clock, asynchronous active-high reset
//   i_rreqN, i_wreqN                 : core-side request pulses per hart
//   o_rreqN, o_wreqN                 : forwarded 1-cycle pulses to each RF interface
//   i_waddrN, i_wdataN, i_wenN       : write port from each RF interface
//   i_raddrN, i_renN                 : read port from each RF interface
//   o_waddr, o_wdata, o_wen          : SRAM write port, address = {owner, waddr}
//   o_raddr, o_ren                   : SRAM read port, address = {owner, raddr}
//   o_busy                           : a burst is active
//   o_err                            : sticky protocol error
module serv_rf_ram_arb
    import serv_rf_arb_pkg::*;
#(
    parameter int width = 8,
    parameter int aw    = 8,
    parameter int BURST = BURST_DEFAULT
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_rreq0,
    input  logic             i_wreq0,
    input  logic             i_rreq1,
    input  logic             i_wreq1,
    output logic             o_rreq0,
    output logic             o_wreq0,
    output logic             o_rreq1,
    output logic             o_wreq1,
    input  logic [aw-1:0]    i_waddr0,
    input  logic [width-1:0] i_wdata0,
    input  logic             i_wen0,
    input  logic [aw-1:0]    i_raddr0,
    input  logic             i_ren0,
    input  logic [aw-1:0]    i_waddr1,
    input  logic [width-1:0] i_wdata1,
    input  logic             i_wen1,
    input  logic [aw-1:0]    i_raddr1,
    input  logic             i_ren1,
    output logic [aw:0]      o_waddr,
    output logic [width-1:0] o_wdata,
    output logic             o_wen,
    output logic [aw:0]      o_raddr,
    output logic             o_ren,
    output logic             o_busy,
    output logic             o_err
);

    localparam logic [CNT_W-1:0] BURST_LAST = CNT_W'(BURST - 1);

    arb_state_t       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    // Pending work per hart as {read, write}.
    logic [1:0]       pend0_q, pend0_d;
    logic [1:0]       pend1_q, pend1_d;
    logic             rreq0_q, rreq0_d;
    logic             wreq0_q, wreq0_d;
    logic             rreq1_q, rreq1_d;
    logic             wreq1_q, wreq1_d;

    logic [1:0]       pend0_eff;
    logic [1:0]       pend1_eff;
    logic             gnt_en;
    logic [1:0]       gnt;
    logic             active;
    logic             owner;

    // Requests arriving this cycle are folded in before arbitration so an idle
    // arbiter forwards them on the very next cycle.
    assign pend0_eff = pend0_q | {i_rreq0, i_wreq0};
    assign pend1_eff = pend1_q | {i_rreq1, i_wreq1};

    // The last cycle of a burst doubles as the idle decision cycle, which is
    // what makes back-to-back bursts gapless.
    assign gnt_en = (state_q == ST_IDLE) || (cnt_q == '0);

    serv_rf_arb_rr u_rr (
        .i_clk  (i_clk),
        .i_rst  (i_rst),
        .i_pend ({|pend1_eff, |pend0_eff}),
        .i_en   (gnt_en),
        .o_gnt  (gnt)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pend0_d = pend0_eff;
        pend1_d = pend1_eff;
        rreq0_d = 1'b0;
        wreq0_d = 1'b0;
        rreq1_d = 1'b0;
        wreq1_d = 1'b0;
        if (gnt_en) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            if (gnt[0]) begin
                state_d = ST_OWN0;
                cnt_d   = BURST_LAST;
                rreq0_d = pend0_eff[1];
                wreq0_d = pend0_eff[0];
                pend0_d = 2'b00;
            end else if (gnt[1]) begin
                state_d = ST_OWN1;
                cnt_d   = BURST_LAST;
                rreq1_d = pend1_eff[1];
                wreq1_d = pend1_eff[0];
                pend1_d = 2'b00;
            end
        end else begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            pend0_q <= 2'b00;
            pend1_q <= 2'b00;
            rreq0_q <= 1'b0;
            wreq0_q <= 1'b0;
            rreq1_q <= 1'b0;
            wreq1_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend0_q <= pend0_d;
            pend1_q <= pend1_d;
            rreq0_q <= rreq0_d;
            wreq0_q <= wreq0_d;
            rreq1_q <= rreq1_d;
            wreq1_q <= wreq1_d;
        end
    end

    assign o_rreq0 = rreq0_q;
    assign o_wreq0 = wreq0_q;
    assign o_rreq1 = rreq1_q;
    assign o_wreq1 = wreq1_q;

    assign active = (state_q != ST_IDLE);
    assign owner  = (state_q == ST_OWN1);
    assign o_busy = active;

    // SRAM port mux: combinational so the RF interface timing is untouched.
    // Everything reads 0 while idle, including addresses and data.
    always_comb begin
        o_waddr = '0;
        o_wdata = '0;
        o_wen   = 1'b0;
        o_raddr = '0;
        o_ren   = 1'b0;
        if (active) begin
            if (owner) begin
                o_waddr = {1'b1, i_waddr1};
                o_wdata = i_wdata1;
                o_wen   = i_wen1;
                o_raddr = {1'b1, i_raddr1};
                o_ren   = i_ren1;
            end else begin
                o_waddr = {1'b0, i_waddr0};
                o_wdata = i_wdata0;
                o_wen   = i_wen0;
                o_raddr = {1'b0, i_raddr0};
                o_ren   = i_ren0;
            end
        end
    end

`ifdef SERV_RF_ARB_ERR_EN
    logic err_q, err_d;
    logic stray;

    always_comb begin
        case (state_q)
            ST_IDLE: stray = i_wen0 | i_ren0 | i_wen1 | i_ren1;
            ST_OWN0: stray = i_wen1 | i_ren1;
            ST_OWN1: stray = i_wen0 | i_ren0;
            default: stray = 1'b0;
        endcase
        err_d = err_q | stray;
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            err_q <= 1'b0;
        end else begin
            err_q <= err_d;
        end
    end

    assign o_err = err_q;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_serv_rf_ram_arb.sv
// tb/tb_serv_rf_ram_arb.sv - scoreboard bench for serv_rf_ram_arb
module tb_serv_rf_ram_arb;

    localparam int W     = 8;
    localparam int AW    = 8;
    localparam int BURST = 36;

`ifdef SERV_RF_ARB_ERR_EN
    localparam bit ERR_ON = 1'b1;
`else
    localparam bit ERR_ON = 1'b0;
`endif

    logic          i_clk = 1'b0;
    logic          i_rst = 1'b1;
    logic          i_rreq0 = 1'b0, i_wreq0 = 1'b0, i_rreq1 = 1'b0, i_wreq1 = 1'b0;
    logic          o_rreq0, o_wreq0, o_rreq1, o_wreq1;
    logic [AW-1:0] i_waddr0 = '0, i_raddr0 = '0, i_waddr1 = '0, i_raddr1 = '0;
    logic [W-1:0]  i_wdata0 = '0, i_wdata1 = '0;
    logic          i_wen0 = 1'b0, i_ren0 = 1'b0, i_wen1 = 1'b0, i_ren1 = 1'b0;
    logic [AW:0]   o_waddr, o_raddr;
    logic [W-1:0]  o_wdata;
    logic          o_wen, o_ren, o_busy, o_err;

    serv_rf_ram_arb #(.width(W), .aw(AW), .BURST(BURST)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_rreq0  (i_rreq0),
        .i_wreq0  (i_wreq0),
        .i_rreq1  (i_rreq1),
        .i_wreq1  (i_wreq1),
        .o_rreq0  (o_rreq0),
        .o_wreq0  (o_wreq0),
        .o_rreq1  (o_rreq1),
        .o_wreq1  (o_wreq1),
        .i_waddr0 (i_waddr0),
        .i_wdata0 (i_wdata0),
        .i_wen0   (i_wen0),
        .i_raddr0 (i_raddr0),
        .i_ren0   (i_ren0),
        .i_waddr1 (i_waddr1),
        .i_wdata1 (i_wdata1),
        .i_wen1   (i_wen1),
        .i_raddr1 (i_raddr1),
        .i_ren1   (i_ren1),
        .o_waddr  (o_waddr),
        .o_wdata  (o_wdata),
        .o_wen    (o_wen),
        .o_raddr  (o_raddr),
        .o_ren    (o_ren),
        .o_busy   (o_busy),
        .o_err    (o_err)
    );

    always #5 i_clk = ~i_clk;

    // Expected forward pulse: cycle it must appear in, and {rreq1,wreq1,rreq0,wreq0}.
    typedef struct {
        int cyc;
        int vec;
    } exp_t;

    exp_t exp_q[$];
    int   errors = 0;
    int   checks = 0;
    bit   mon_en = 1'b0;

    // Reference model: time-based view of bursts (cycle numbers), not a counter.
    int       m_cyc;
    int       m_next_free;
    int       m_busy_lo;
    int       m_busy_hi;
    int       m_owner;
    int       m_last;
    bit [1:0] m_pend [2];
    bit       m_err;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=0x%0h exp=0x%0h", name, m_cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_cyc       = 0;
        m_next_free = 0;
        m_busy_lo   = 1;
        m_busy_hi   = 0;
        m_owner     = 0;
        m_last      = 1;
        m_pend[0]   = 2'b00;
        m_pend[1]   = 2'b00;
        m_err       = 1'b0;
        exp_q.delete();
    endtask

    // Called at each rising edge with the inputs the DUT just sampled.
    task automatic model_update();
        bit   in_b;
        bit   s0;
        bit   s1;
        int   h;
        exp_t e;
        in_b = (m_cyc >= m_busy_lo) && (m_cyc <= m_busy_hi);
        s0   = i_wen0 | i_ren0;
        s1   = i_wen1 | i_ren1;
        if (ERR_ON) begin
            if (!in_b && (s0 || s1)) m_err = 1'b1;
            if (in_b && ((m_owner == 0) ? s1 : s0)) m_err = 1'b1;
        end
        m_pend[0] = m_pend[0] | {i_rreq0, i_wreq0};
        m_pend[1] = m_pend[1] | {i_rreq1, i_wreq1};
        if (m_cyc >= m_next_free && (m_pend[0] != 0 || m_pend[1] != 0)) begin
            if (m_pend[0] != 0 && m_pend[1] != 0) h = 1 - m_last;
            else                                  h = (m_pend[0] != 0) ? 0 : 1;
            e.cyc = m_cyc + 1;
            e.vec = (h == 1) ? (int'(m_pend[1]) << 2) : int'(m_pend[0]);
            exp_q.push_back(e);
            m_pend[h]   = 2'b00;
            m_last      = h;
            m_owner     = h;
            m_busy_lo   = m_cyc + 1;
            m_busy_hi   = m_cyc + BURST;
            m_next_free = m_cyc + BURST;
        end
        m_cyc++;
    endtask

    // Monitor: mid-cycle check of the SRAM mux, busy, err and forward pulses.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        int   k;
        bit   busy;
        int   vec;
        int   era, ewa, ewd, er, ew;
        if (mon_en && !i_rst) begin
            k    = m_cyc;
            busy = (k >= m_busy_lo) && (k <= m_busy_hi);
            era = 0; ewa = 0; ewd = 0; er = 0; ew = 0;
            if (busy) begin
                if (m_owner == 1) begin
                    era = (1 << AW) | int'(i_raddr1);
                    ewa = (1 << AW) | int'(i_waddr1);
                    ewd = int'(i_wdata1);
                    er  = int'(i_ren1);
                    ew  = int'(i_wen1);
                end else begin
                    era = int'(i_raddr0);
                    ewa = int'(i_waddr0);
                    ewd = int'(i_wdata0);
                    er  = int'(i_ren0);
                    ew  = int'(i_wen0);
                end
            end
            chk("busy", int'(o_busy), int'(busy));
            chk("raddr", int'(o_raddr), era);
            chk("ren", int'(o_ren), er);
            chk("waddr", int'(o_waddr), ewa);
            chk("wdata", int'(o_wdata), ewd);
            chk("wen", int'(o_wen), ew);
            chk("err", int'(o_err), int'(m_err));
            vec = int'({o_rreq1, o_wreq1, o_rreq0, o_wreq0});
            if (vec != 0) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pulse", vec, 0);
                end else begin
                    e = exp_q.pop_front();
                    chk("pulse_cycle", k, e.cyc);
                    chk("pulse_harts", vec, e.vec);
                end
            end else if (exp_q.size() != 0 && exp_q[0].cyc <= k) begin
                e = exp_q.pop_front();
                chk("missed_pulse", 0, e.vec);
            end
        end
    end

    task automatic tick();
        @(posedge i_clk);
        model_update();
        #1;
        i_rreq0 = 1'b0;
        i_wreq0 = 1'b0;
        i_rreq1 = 1'b0;
        i_wreq1 = 1'b0;
    endtask

    task automatic clear_ram_inputs();
        i_waddr0 = '0; i_raddr0 = '0; i_wdata0 = '0; i_wen0 = 1'b0; i_ren0 = 1'b0;
        i_waddr1 = '0; i_raddr1 = '0; i_wdata1 = '0; i_wen1 = 1'b0; i_ren1 = 1'b0;
    endtask

    task automatic rand_ram_inputs();
        i_waddr0 = AW'($urandom); i_raddr0 = AW'($urandom); i_wdata0 = W'($urandom);
        i_waddr1 = AW'($urandom); i_raddr1 = AW'($urandom); i_wdata1 = W'($urandom);
        i_wen0 = 1'($urandom_range(0, 1)); i_ren0 = 1'($urandom_range(0, 1));
        i_wen1 = 1'($urandom_range(0, 1)); i_ren1 = 1'($urandom_range(0, 1));
    endtask

    task automatic wait_idle(input int bound);
        int n;
        n = 0;
        while (!(exp_q.size() == 0 && m_pend[0] == 0 && m_pend[1] == 0 && m_cyc > m_busy_hi)
               && n < bound) begin
            tick();
            n++;
        end
        if (n >= bound) begin
            checks++;
            errors++;
            $display("FAIL wait_idle_timeout cyc=%0d bound=%0d", m_cyc, bound);
        end
    endtask

    // Entered at posedge+1; leaves at posedge+1 with cycle numbering restarted.
    task automatic do_reset();
        i_rst = 1'b1;
        clear_ram_inputs();
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge i_clk);

        // Reset state.
        @(negedge i_clk);
        chk("rst_busy", int'(o_busy), 0);
        chk("rst_reqs", int'({o_rreq1, o_wreq1, o_rreq0, o_wreq0}), 0);
        chk("rst_waddr", int'(o_waddr), 0);
        chk("rst_raddr", int'(o_raddr), 0);
        chk("rst_wdata", int'(o_wdata), 0);
        chk("rst_wen", int'(o_wen), 0);
        chk("rst_ren", int'(o_ren), 0);
        chk("rst_err", int'(o_err), 0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        mon_en = 1'b1;

        // Single read request at cycle 5: pulse at 6, busy 6..41.
        repeat (5) tick();
        i_rreq0 = 1'b1;
        tick();
        wait_idle(200);

        // Simultaneous hart 0 read and hart 1 write after reset.
        do_reset();
        repeat (5) tick();
        i_rreq0 = 1'b1;
        i_wreq1 = 1'b1;
        tick();
        wait_idle(200);

        // Hart 1 owns; hart 0 also strobes read.
        i_rreq1 = 1'b1;
        tick();
        tick();
        i_raddr1 = 8'h12;
        i_ren1   = 1'b1;
        i_raddr0 = 8'h34;
        i_ren0   = 1'b1;
        @(negedge i_clk);
        chk("owner1_raddr", int'(o_raddr), 'h112);
        chk("owner1_ren", int'(o_ren), 1);
        tick();
        clear_ram_inputs();
        wait_idle(200);

        // Repeated ties.
        for (int t = 0; t < 4; t++) begin
            i_rreq0 = 1'b1;
            i_rreq1 = 1'b1;
            i_wreq0 = 1'($urandom_range(0, 1));
            tick();
            wait_idle(300);
        end

        // Randomized traffic.
        for (int c = 0; c < 1500; c++) begin
            rand_ram_inputs();
            i_rreq0 = ($urandom_range(0, 15) == 0);
            i_wreq0 = ($urandom_range(0, 15) == 0);
            i_rreq1 = ($urandom_range(0, 15) == 0);
            i_wreq1 = ($urandom_range(0, 15) == 0);
            tick();
        end
        clear_ram_inputs();
        wait_idle(400);

        // Reset mid-burst with counter at 10 and hart 1 queued.
        do_reset();
        i_wreq0 = 1'b1;
        tick();
        i_rreq1 = 1'b1;
        tick();
        for (int n = 0; n < 100 && (m_busy_hi - m_cyc) != 10; n++) tick();
        chk("rst_mid_counter", m_busy_hi - m_cyc, 10);
        #2;
        i_rst = 1'b1;
        #1;
        chk("rst_async_busy", int'(o_busy), 0);
        chk("rst_async_reqs", int'({o_rreq1, o_wreq1, o_rreq0, o_wreq0}), 0);
        repeat (2) @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        model_reset();
        repeat (10) tick();
        i_wreq1 = 1'b1;
        tick();
        wait_idle(200);

        // Stray write enable while idle.
        do_reset();
        repeat (3) tick();
        i_wen0   = 1'b1;
        i_waddr0 = 8'h05;
        tick();
        i_wen0 = 1'b0;
        repeat (3) tick();
        @(negedge i_clk);
        chk("err_sticky", int'(o_err), int'(ERR_ON));
        chk("err_wen_blocked", int'(o_wen), 0);
        tick();

        chk("queue_empty", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
